// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: FSM encoding, opcode constants and IR field positions shared with the datapath
package fetch_unit_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2} fetch_state_t;
  localparam logic [4:0] OP_BRANCH = 5'b10010;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI = 26;
  localparam int RA_LO = 23;
  localparam int RB_HI = 22;
  localparam int RB_LO = 19;
  localparam int RC_HI = 18;
  localparam int RC_LO = 15;
  localparam int BR_HI = 20;
  localparam int BR_LO = 19;
  localparam int IMM_HI = 18;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with timeout, flush, instruction register and field decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iFetch,
  input  logic        iFlush,
  input  logic        iIR_ack,
  input  logic        iMemRdy,
  input  logic [31:0] iMemData,
  output logic        oMemRd,
  output logic        oPC_inc,
  output logic        oIR_valid,
  output logic        oBusy,
  output logic        oFetchErr,
  output logic [31:0] oIR,
  output logic [4:0]  oOpcode,
  output logic [3:0]  oRF_AddrA,
  output logic [3:0]  oRF_AddrB,
  output logic [3:0]  oRF_AddrC,
  output logic [31:0] oImm32,
  output logic [1:0]  oBrCond
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  fetch_state_t state, state_n;
  logic [31:0] ir, ir_n;
  logic [CW-1:0] cnt, cnt_n;
  logic pc_inc, pc_inc_n, err, err_n;
  // state, IR, wait counter, PC pulse and error flag registers
  always_ff @(posedge iClk) begin
    if (!nRst) begin
      state <= IDLE;
      ir <= '0;
      cnt <= '0;
      pc_inc <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      ir <= ir_n;
      cnt <= cnt_n;
      pc_inc <= pc_inc_n;
      err <= err_n;
    end
  end
  // next-state logic; flush overrides every other input and kills any load in its cycle
  always_comb begin
    state_n = state;
    ir_n = ir;
    cnt_n = cnt;
    pc_inc_n = 1'b0;
    err_n = err;
    if (iFlush) state_n = IDLE;
    else
      case (state)
        IDLE:
          if (iFetch) begin
            state_n = REQ;
            err_n = 1'b0;
            cnt_n = '0;
          end
        REQ:
          if (iMemRdy) begin
            state_n = HOLD;
            ir_n = iMemData;
            pc_inc_n = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
            if (cnt_n == CW'(WAIT_MAX)) begin
              state_n = IDLE;
              err_n = 1'b1;
            end
          end
        HOLD:
          if (iIR_ack) begin
            state_n = iFetch ? REQ : IDLE;
            err_n = iFetch ? 1'b0 : err;
            cnt_n = iFetch ? '0 : cnt;
          end
        default: state_n = IDLE;
      endcase
  end
  assign oMemRd = state == REQ;
  assign oBusy = state == REQ;
  assign oIR_valid = state == HOLD;
  assign oPC_inc = pc_inc;
  assign oFetchErr = err;
  assign oIR = ir;
  // decode works from the IR register alone so fields stay stable for the whole HOLD period;
  // branches test their condition register on port B, so B mirrors A for them
  assign oOpcode = ir[OPC_HI:OPC_LO];
  assign oRF_AddrA = ir[RA_HI:RA_LO];
  assign oRF_AddrB = oOpcode == OP_BRANCH ? ir[RA_HI:RA_LO] : ir[RB_HI:RB_LO];
  assign oRF_AddrC = ir[RC_HI:RC_LO];
  assign oImm32 = {{(31 - IMM_HI){ir[IMM_HI]}}, ir[IMM_HI:0]};
  assign oBrCond = ir[BR_HI:BR_LO];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, decode, timeout, flush, reset and back-to-back behaviour
module tb_fetch_unit;
  logic iClk = 1'b0, nRst = 1'b0, iFetch = 1'b0, iFlush = 1'b0, iIR_ack = 1'b0, iMemRdy = 1'b0;
  logic [31:0] iMemData = '0;
  logic oMemRd, oPC_inc, oIR_valid, oBusy, oFetchErr;
  logic [31:0] oIR, oImm32;
  logic [4:0] oOpcode;
  logic [3:0] oRF_AddrA, oRF_AddrB, oRF_AddrC;
  logic [1:0] oBrCond;
  int n_chk = 0, n_fail = 0, n_rd;

  fetch_unit #(.WAIT_MAX(15)) dut (
    .iClk(iClk), .nRst(nRst), .iFetch(iFetch), .iFlush(iFlush), .iIR_ack(iIR_ack),
    .iMemRdy(iMemRdy), .iMemData(iMemData), .oMemRd(oMemRd), .oPC_inc(oPC_inc),
    .oIR_valid(oIR_valid), .oBusy(oBusy), .oFetchErr(oFetchErr), .oIR(oIR),
    .oOpcode(oOpcode), .oRF_AddrA(oRF_AddrA), .oRF_AddrB(oRF_AddrB), .oRF_AddrC(oRF_AddrC),
    .oImm32(oImm32), .oBrCond(oBrCond)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_memrd"}, 32'(oMemRd), 0);
    check({tag, "_pcinc"}, 32'(oPC_inc), 0);
    check({tag, "_valid"}, 32'(oIR_valid), 0);
    check({tag, "_busy"}, 32'(oBusy), 0);
    check({tag, "_err"}, 32'(oFetchErr), 0);
    check({tag, "_ir"}, oIR, 0);
  endtask

  initial begin
    step();
    step();
    check_idle_zero("reset");
    nRst = 1'b1;
    // normal fetch, data on third REQ cycle
    iFetch = 1'b1;
    step();
    iFetch = 1'b0;
    check("req1_memrd", 32'(oMemRd), 1);
    check("req1_busy", 32'(oBusy), 1);
    check("req1_valid", 32'(oIR_valid), 0);
    step();
    step();
    check("req3_memrd", 32'(oMemRd), 1);
    iMemRdy = 1'b1;
    iMemData = 32'h0A9C_0005;
    step();
    iMemRdy = 1'b0;
    check("hold_valid", 32'(oIR_valid), 1);
    check("hold_pcinc", 32'(oPC_inc), 1);
    check("hold_memrd", 32'(oMemRd), 0);
    check("n_ir", oIR, 32'h0A9C_0005);
    check("n_opc", 32'(oOpcode), 32'h01);
    check("n_ra", 32'(oRF_AddrA), 5);
    check("n_rb", 32'(oRF_AddrB), 3);
    check("n_rc", 32'(oRF_AddrC), 8);
    check("n_imm", oImm32, 32'hFFFC_0005);
    check("n_br", 32'(oBrCond), 3);
    step();
    check("hold2_pcinc", 32'(oPC_inc), 0);
    check("hold2_valid", 32'(oIR_valid), 1);
    iFetch = 1'b1;
    step();
    check("hold_ignore_fetch", 32'(oIR_valid), 1);
    // back-to-back: ack with fetch goes straight to REQ
    iIR_ack = 1'b1;
    step();
    iIR_ack = 1'b0;
    iFetch = 1'b0;
    check("b2b_memrd", 32'(oMemRd), 1);
    check("b2b_valid", 32'(oIR_valid), 0);
    iMemRdy = 1'b1;
    iMemData = 32'h0807_FFFF;
    step();
    iMemRdy = 1'b0;
    check("sx_valid", 32'(oIR_valid), 1);
    check("sx_imm", oImm32, 32'hFFFF_FFFF);
    check("sx_opc", 32'(oOpcode), 32'h01);
    // ack alone returns to IDLE
    iIR_ack = 1'b1;
    step();
    iIR_ack = 1'b0;
    check("ack_valid", 32'(oIR_valid), 0);
    check("ack_memrd", 32'(oMemRd), 0);
    // branch remapping, data in first REQ cycle
    iFetch = 1'b1;
    step();
    iFetch = 1'b0;
    iMemRdy = 1'b1;
    iMemData = 32'h9288_0000;
    step();
    iMemRdy = 1'b0;
    check("br_opc", 32'(oOpcode), 32'h12);
    check("br_ra", 32'(oRF_AddrA), 5);
    check("br_rb", 32'(oRF_AddrB), 5);
    check("br_cond", 32'(oBrCond), 1);
    check("br_rc", 32'(oRF_AddrC), 0);
    check("br_imm", oImm32, 0);
    // flush colliding with memory ready in REQ
    iIR_ack = 1'b1;
    iFetch = 1'b1;
    step();
    iIR_ack = 1'b0;
    iFetch = 1'b0;
    check("fl_req", 32'(oMemRd), 1);
    iFlush = 1'b1;
    iMemRdy = 1'b1;
    iMemData = 32'hDEAD_BEEF;
    step();
    iFlush = 1'b0;
    iMemRdy = 1'b0;
    check("fl_ir", oIR, 32'h9288_0000);
    check("fl_pcinc", 32'(oPC_inc), 0);
    check("fl_memrd", 32'(oMemRd), 0);
    check("fl_valid", 32'(oIR_valid), 0);
    step();
    check("fl_pcinc2", 32'(oPC_inc), 0);
    // timeout: count strobe cycles under a bound
    iFetch = 1'b1;
    step();
    iFetch = 1'b0;
    n_rd = 0;
    while (oMemRd && n_rd < 40) begin
      n_rd++;
      step();
    end
    check("to_cycles", 32'(n_rd), 15);
    check("to_err", 32'(oFetchErr), 1);
    check("to_busy", 32'(oBusy), 0);
    check("to_valid", 32'(oIR_valid), 0);
    check("to_ir", oIR, 32'h9288_0000);
    check("to_pcinc", 32'(oPC_inc), 0);
    step();
    step();
    check("to_sticky", 32'(oFetchErr), 1);
    iFetch = 1'b1;
    step();
    iFetch = 1'b0;
    check("to_clr_err", 32'(oFetchErr), 0);
    check("to_clr_memrd", 32'(oMemRd), 1);
    // reset colliding with memory ready in REQ
    nRst = 1'b0;
    iMemRdy = 1'b1;
    iMemData = 32'h1234_5678;
    step();
    nRst = 1'b1;
    iMemRdy = 1'b0;
    check_idle_zero("rst_req");
    step();
    check("rst_req_pcinc2", 32'(oPC_inc), 0);
    // reset in HOLD while the PC pulse is live
    iFetch = 1'b1;
    step();
    iFetch = 1'b0;
    iMemRdy = 1'b1;
    iMemData = 32'h0A9C_0005;
    step();
    iMemRdy = 1'b0;
    check("rh_valid", 32'(oIR_valid), 1);
    nRst = 1'b0;
    step();
    nRst = 1'b1;
    check_idle_zero("rst_hold");
    check("rst_hold_opc", 32'(oOpcode), 0);
    check("rst_hold_imm", oImm32, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
